// File: rtl/dmax_pkg.sv
// Shared definitions for the DMAX glyph writer: bus constants, FSM state
// encoding, the packed glyph type and small helpers used by the ROM and top.
package dmax_pkg;

   localparam logic [15:0] DMAX_DEV_ADDR = 16'h0040;
   localparam logic [4:0]  OP_SHIFT_IN   = 5'b00001;
   localparam int          GLYPH_W       = 5;
   localparam int          GLYPH_H       = 7;
   localparam int          DMAX_COLS     = 30;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EMIT,
      ST_WAIT,
      ST_CLR
   } state_t;

   // glyph[c] is column c (0 = leftmost); bit r of a column is pixel row r (0 = top).
   typedef logic [GLYPH_W-1:0][GLYPH_H-1:0] glyph_t;

   localparam glyph_t SOLID_GLYPH = '1;

   // Assemble a glyph from its columns listed left to right.
   function automatic glyph_t make_glyph(input logic [6:0] c0, input logic [6:0] c1,
                                         input logic [6:0] c2, input logic [6:0] c3,
                                         input logic [6:0] c4);
      make_glyph = {c4, c3, c2, c1, c0};
   endfunction

   // Bus data word for a single shift-in of one column.
   function automatic logic [15:0] shift_word(input logic [6:0] col);
      shift_word = {OP_SHIFT_IN, 4'b0000, col};
   endfunction

endpackage

// File: rtl/dmax_font_rom.sv
// 64-entry 5x7 font ROM for codes 8'h20..8'h5F with a one-cycle registered read.
// Any other code returns a solid block so bad input is visible on the display.
module dmax_font_rom
   import dmax_pkg::*;
(
   input  logic        clk,
   input  logic [7:0]  code,
   output logic [34:0] glyph
);

   // Registered lookup; columns are given left to right, bit 0 = top row.
   // NOTE: ROM output and other pure data registers carry no reset; the FSM never consumes them before they are loaded.
   always_ff @(posedge clk) begin
      case (code)
         8'h20: glyph <= make_glyph(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
         8'h21: glyph <= make_glyph(7'h00, 7'h00, 7'h5F, 7'h00, 7'h00);
         8'h22: glyph <= make_glyph(7'h00, 7'h07, 7'h00, 7'h07, 7'h00);
         8'h23: glyph <= make_glyph(7'h14, 7'h7F, 7'h14, 7'h7F, 7'h14);
         8'h24: glyph <= make_glyph(7'h24, 7'h2A, 7'h7F, 7'h2A, 7'h12);
         8'h25: glyph <= make_glyph(7'h23, 7'h13, 7'h08, 7'h64, 7'h62);
         8'h26: glyph <= make_glyph(7'h36, 7'h49, 7'h55, 7'h22, 7'h50);
         8'h27: glyph <= make_glyph(7'h00, 7'h05, 7'h03, 7'h00, 7'h00);
         8'h28: glyph <= make_glyph(7'h00, 7'h1C, 7'h22, 7'h41, 7'h00);
         8'h29: glyph <= make_glyph(7'h00, 7'h41, 7'h22, 7'h1C, 7'h00);
         8'h2A: glyph <= make_glyph(7'h08, 7'h2A, 7'h1C, 7'h2A, 7'h08);
         8'h2B: glyph <= make_glyph(7'h08, 7'h08, 7'h3E, 7'h08, 7'h08);
         8'h2C: glyph <= make_glyph(7'h00, 7'h50, 7'h30, 7'h00, 7'h00);
         8'h2D: glyph <= make_glyph(7'h08, 7'h08, 7'h08, 7'h08, 7'h08);
         8'h2E: glyph <= make_glyph(7'h00, 7'h60, 7'h60, 7'h00, 7'h00);
         8'h2F: glyph <= make_glyph(7'h20, 7'h10, 7'h08, 7'h04, 7'h02);
         8'h30: glyph <= make_glyph(7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E);
         8'h31: glyph <= make_glyph(7'h00, 7'h42, 7'h7F, 7'h40, 7'h00);
         8'h32: glyph <= make_glyph(7'h42, 7'h61, 7'h51, 7'h49, 7'h46);
         8'h33: glyph <= make_glyph(7'h21, 7'h41, 7'h45, 7'h4B, 7'h31);
         8'h34: glyph <= make_glyph(7'h18, 7'h14, 7'h12, 7'h7F, 7'h10);
         8'h35: glyph <= make_glyph(7'h27, 7'h45, 7'h45, 7'h45, 7'h39);
         8'h36: glyph <= make_glyph(7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30);
         8'h37: glyph <= make_glyph(7'h01, 7'h71, 7'h09, 7'h05, 7'h03);
         8'h38: glyph <= make_glyph(7'h36, 7'h49, 7'h49, 7'h49, 7'h36);
         8'h39: glyph <= make_glyph(7'h06, 7'h49, 7'h49, 7'h29, 7'h1E);
         8'h3A: glyph <= make_glyph(7'h00, 7'h36, 7'h36, 7'h00, 7'h00);
         8'h3B: glyph <= make_glyph(7'h00, 7'h56, 7'h36, 7'h00, 7'h00);
         8'h3C: glyph <= make_glyph(7'h00, 7'h08, 7'h14, 7'h22, 7'h41);
         8'h3D: glyph <= make_glyph(7'h14, 7'h14, 7'h14, 7'h14, 7'h14);
         8'h3E: glyph <= make_glyph(7'h41, 7'h22, 7'h14, 7'h08, 7'h00);
         8'h3F: glyph <= make_glyph(7'h02, 7'h01, 7'h51, 7'h09, 7'h06);
         8'h40: glyph <= make_glyph(7'h32, 7'h49, 7'h79, 7'h41, 7'h3E);
         8'h41: glyph <= make_glyph(7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E);
         8'h42: glyph <= make_glyph(7'h7F, 7'h49, 7'h49, 7'h49, 7'h36);
         8'h43: glyph <= make_glyph(7'h3E, 7'h41, 7'h41, 7'h41, 7'h22);
         8'h44: glyph <= make_glyph(7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C);
         8'h45: glyph <= make_glyph(7'h7F, 7'h49, 7'h49, 7'h49, 7'h41);
         8'h46: glyph <= make_glyph(7'h7F, 7'h09, 7'h09, 7'h01, 7'h01);
         8'h47: glyph <= make_glyph(7'h3E, 7'h41, 7'h41, 7'h51, 7'h32);
         8'h48: glyph <= make_glyph(7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F);
         8'h49: glyph <= make_glyph(7'h00, 7'h41, 7'h7F, 7'h41, 7'h00);
         8'h4A: glyph <= make_glyph(7'h20, 7'h40, 7'h41, 7'h3F, 7'h01);
         8'h4B: glyph <= make_glyph(7'h7F, 7'h08, 7'h14, 7'h22, 7'h41);
         8'h4C: glyph <= make_glyph(7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);
         8'h4D: glyph <= make_glyph(7'h7F, 7'h02, 7'h04, 7'h02, 7'h7F);
         8'h4E: glyph <= make_glyph(7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F);
         8'h4F: glyph <= make_glyph(7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E);
         8'h50: glyph <= make_glyph(7'h7F, 7'h09, 7'h09, 7'h09, 7'h06);
         8'h51: glyph <= make_glyph(7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E);
         8'h52: glyph <= make_glyph(7'h7F, 7'h09, 7'h19, 7'h29, 7'h46);
         8'h53: glyph <= make_glyph(7'h46, 7'h49, 7'h49, 7'h49, 7'h31);
         8'h54: glyph <= make_glyph(7'h01, 7'h01, 7'h7F, 7'h01, 7'h01);
         8'h55: glyph <= make_glyph(7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F);
         8'h56: glyph <= make_glyph(7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F);
         8'h57: glyph <= make_glyph(7'h7F, 7'h20, 7'h18, 7'h20, 7'h7F);
         8'h58: glyph <= make_glyph(7'h63, 7'h14, 7'h08, 7'h14, 7'h63);
         8'h59: glyph <= make_glyph(7'h03, 7'h04, 7'h78, 7'h04, 7'h03);
         8'h5A: glyph <= make_glyph(7'h61, 7'h51, 7'h49, 7'h45, 7'h43);
         8'h5B: glyph <= make_glyph(7'h00, 7'h00, 7'h7F, 7'h41, 7'h41);
         8'h5C: glyph <= make_glyph(7'h02, 7'h04, 7'h08, 7'h10, 7'h20);
         8'h5D: glyph <= make_glyph(7'h41, 7'h41, 7'h7F, 7'h00, 7'h00);
         8'h5E: glyph <= make_glyph(7'h04, 7'h02, 7'h01, 7'h02, 7'h04);
         8'h5F: glyph <= make_glyph(7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
         default: glyph <= SOLID_GLYPH;
      endcase
   end

endmodule

// File: rtl/dmax_glyph_writer.sv
// Feeds the DMAX dot-matrix driver: takes one character per valid/ready
// handshake, fetches its glyph and shifts the columns (plus blank spacing
// columns) onto the DEVICE/DATA bus as single-cycle writes. A clear request
// shifts in a full display width of empty columns instead.
module dmax_glyph_writer
   import dmax_pkg::*;
#(
   parameter logic [15:0] DEV_ADDR      = DMAX_DEV_ADDR,
   parameter int          WRITE_SPACING = 4,
   parameter int          BLANK_COLS    = 1,
   parameter int          CLEAR_COLS    = DMAX_COLS
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        char_valid,
   input  logic [7:0]  char_code,
   output logic        char_ready,
   input  logic        clear_req,
   output logic        busy,
   output logic [15:0] DEVICE,
   output logic [15:0] DATA
);

   // Spacing counter must hold the full spacing, used for the trailing gap after the last write.
   localparam int                CNT_W       = (WRITE_SPACING < 2) ? 1 : $clog2(WRITE_SPACING + 1);
   localparam logic [CNT_W-1:0]  SPACE_FULL  = CNT_W'(WRITE_SPACING);
   localparam logic [CNT_W-1:0]  SPACE_GAP   = CNT_W'(WRITE_SPACING - 1);
   localparam logic [4:0]        GLYPH_TOTAL = 5'(GLYPH_W + BLANK_COLS);
   localparam logic [4:0]        CLEAR_TOTAL = 5'(CLEAR_COLS);

   state_t             state, state_n;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
   logic [4:0]         col_cnt, col_cnt_n;
   logic [4:0]         col_inc;
   logic [4:0]         col_total;
   logic               clearing, clearing_n;
   logic               load_code;
   logic               write_en;
   logic [6:0]         write_col;
   logic [7:0]         code_q;
   logic [34:0]        glyph_raw;
   glyph_t             glyph;

   dmax_font_rom u_font_rom (
      .clk   (clk),
      .code  (code_q),
      .glyph (glyph_raw)
   );

   assign glyph      = glyph_raw;
   assign char_ready = (state == ST_IDLE) && !clear_req;
   assign busy       = (state != ST_IDLE);
   assign col_inc    = col_cnt + 5'd1;
   assign col_total  = clearing ? CLEAR_TOTAL : GLYPH_TOTAL;

   // Hold the accepted code so upstream may change char_code right after the handshake.
   always_ff @(posedge clk) begin
      if (load_code) begin
         code_q <= char_code;
      end
   end

   // Next-state logic: handshake, column sequencing and write spacing.
   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      col_cnt_n  = col_cnt;
      clearing_n = clearing;
      load_code  = 1'b0;
      write_en   = 1'b0;
      write_col  = 7'h00;

      case (state)
         ST_IDLE: begin
            if (clear_req) begin
               state_n    = ST_CLR;
               col_cnt_n  = 5'd0;
               clearing_n = 1'b1;
            end else if (char_valid) begin
               state_n    = ST_LOAD;
               col_cnt_n  = 5'd0;
               clearing_n = 1'b0;
               load_code  = 1'b1;
            end
         end

         ST_LOAD: begin
            state_n = ST_EMIT;
         end

         ST_EMIT, ST_CLR: begin
            write_en  = 1'b1;
            if (!clearing && (col_cnt < 5'(GLYPH_W))) begin
               write_col = glyph[col_cnt[2:0]];
            end
            col_cnt_n = col_inc;
            if (col_inc == col_total) begin
               // Last write still gets a full spacing slot before returning to idle.
               state_n    = ST_WAIT;
               wait_cnt_n = SPACE_FULL;
            end else if (WRITE_SPACING > 1) begin
               state_n    = ST_WAIT;
               wait_cnt_n = SPACE_GAP;
            end
         end

         ST_WAIT: begin
            if (wait_cnt <= CNT_W'(1)) begin
               if (col_cnt == col_total) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = clearing ? ST_CLR : ST_EMIT;
               end
            end else begin
               wait_cnt_n = wait_cnt - CNT_W'(1);
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered bus outputs; reset drops any write in flight.
   // NOTE: sequential state is updated with non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         col_cnt  <= 5'd0;
         clearing <= 1'b0;
         DEVICE   <= 16'h0000;
         DATA     <= 16'h0000;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         col_cnt  <= col_cnt_n;
         clearing <= clearing_n;
         DEVICE   <= write_en ? DEV_ADDR : 16'h0000;
         DATA     <= write_en ? shift_word(write_col) : 16'h0000;
      end
   end

endmodule

// File: tb/tb_dmax_glyph_writer.sv
// Bench for dmax_glyph_writer: a scoreboard built from the write schedule
// (cycle and data of every expected shift) checks the default-spacing
// instance under directed and random traffic; a second instance with
// WRITE_SPACING=1 is checked for back-to-back writes.
module tb_dmax_glyph_writer;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        char_valid = 1'b0;
   logic [7:0]  char_code = 8'h00;
   logic        clear_req = 1'b0;
   logic        char_ready, busy;
   logic [15:0] DEVICE, DATA;

   logic        f_valid = 1'b0;
   logic [7:0]  f_code = 8'h00;
   logic        f_clear = 1'b0;
   logic        f_ready, f_busy;
   logic [15:0] f_dev, f_data;

   always #5 clk = ~clk;

   dmax_glyph_writer dut (
      .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
      .char_ready(char_ready), .clear_req(clear_req), .busy(busy),
      .DEVICE(DEVICE), .DATA(DATA)
   );

   dmax_glyph_writer #(.WRITE_SPACING(1)) dut_fast (
      .clk(clk), .rst(rst), .char_valid(f_valid), .char_code(f_code),
      .char_ready(f_ready), .clear_req(f_clear), .busy(f_busy),
      .DEVICE(f_dev), .DATA(f_data)
   );

   typedef struct {
      int          cyc;       // absolute cycle, or offset from first clear write when rel
      bit          rel;
      bit          last_clr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   int  ready_due = 0;
   int  base = 0;
   int  wr_total = 0;
   int  acc_total = 0;
   bit  rst_prev = 1'b1;
   bit  prev_dev = 1'b0;
   bit  model_idle = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
   endtask

   // Column k of the glyph shifted for a code; only codes the bench issues are modelled.
   function automatic logic [6:0] model_col(input logic [7:0] code, input int k);
      if (k >= 5) return 7'h00;
      if (code == 8'h41) return (k == 0 || k == 4) ? 7'h7E : 7'h09;
      return 7'h7F;
   endfunction

   function automatic logic [7:0] pick_code();
      int r;
      if ($urandom_range(0, 1) == 1) return 8'h41;
      r = int'($urandom_range(0, 191));
      if (r < 32) return 8'(r);
      return 8'(r + 64);
   endfunction

   function automatic int head_cyc();
      if (!exp_q[0].rel) return exp_q[0].cyc;
      if (exp_q[0].cyc == 0) return -1;
      return base + exp_q[0].cyc;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // Scoreboard monitor for the default instance, sampled after the falling edge.
   always @(negedge clk) begin
      wr_t e;
      int  want;
      bit  idle;
      #2;
      if (rst_prev) begin
         check("rst_device", 32'(DEVICE), 32'h0);
         check("rst_data", 32'(DATA), 32'h0);
      end else begin
         if (DEVICE != 16'h0000) begin
            wr_total++;
            check("dev_pulse", 32'(prev_dev), 32'h0);
            if (exp_q.size() == 0) begin
               check("spurious_wr", 32'(DEVICE), 32'h0);
            end else begin
               e = exp_q.pop_front();
               if (e.rel && e.cyc == 0) base = cyc;
               want = e.rel ? base + e.cyc : e.cyc;
               check("wr_cycle", cyc, want);
               check("wr_device", 32'(DEVICE), 32'h0040);
               check("wr_data", 32'(DATA), 32'(e.data));
               if (e.last_clr) ready_due = want + S;
            end
         end else begin
            check("idle_data", 32'(DATA), 32'h0);
            if (exp_q.size() > 0) begin
               want = head_cyc();
               if (want >= 0 && want <= cyc) begin
                  e = exp_q.pop_front();
                  check("missed_wr", 32'(DEVICE), 32'h0040);
                  if (e.last_clr) ready_due = want + S;
               end
            end
         end
         idle = (exp_q.size() == 0) && (cyc >= ready_due);
         check("busy", 32'(busy), 32'(!idle));
         check("char_ready", 32'(char_ready), 32'(idle && !clear_req));
      end
      prev_dev = (DEVICE != 16'h0000);

      if (rst) begin
         exp_q.delete();
         ready_due = 0;
      end else if ((exp_q.size() == 0) && (cyc >= ready_due)) begin
         if (clear_req) begin
            for (int k = 0; k < 30; k++) begin
               e.cyc = k * S; e.rel = 1'b1; e.last_clr = (k == 29); e.data = 16'h0800;
               exp_q.push_back(e);
            end
            ready_due = 0;
         end else if (char_valid) begin
            for (int k = 0; k < 6; k++) begin
               e.cyc = cyc + 1 + 2 + k * S; e.rel = 1'b0; e.last_clr = 1'b0;
               e.data = {5'b00001, 4'b0000, model_col(char_code, k)};
               exp_q.push_back(e);
            end
            ready_due = cyc + 1 + 2 + 6 * S;
            acc_total++;
         end
      end
      model_idle = (exp_q.size() == 0) && (cyc >= ready_due);
      rst_prev = rst;
   end

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (model_idle) return;
         @(negedge clk);
      end
      check("idle_timeout", 32'(model_idle), 32'h1);
   endtask

   task automatic send_char(input logic [7:0] code);
      wait_idle();
      @(negedge clk);
      char_valid = 1'b1;
      char_code  = code;
      @(negedge clk);
      char_valid = 1'b0;
      char_code  = 8'($urandom);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #3;
      check("ready_after_rst", 32'(char_ready), 32'h1);
      check("busy_after_rst", 32'(busy), 32'h0);
   endtask

   task automatic fast_test();
      int t;
      int first_rdy;
      int cyc_q[$];
      logic [15:0] dat_q[$];
      @(negedge clk);
      #2;
      check("fast_ready_idle", 32'(f_ready), 32'h1);
      f_valid = 1'b1;
      f_code  = 8'h41;
      t = cyc + 1;
      @(negedge clk);
      f_valid = 1'b0;
      f_code  = 8'h00;
      first_rdy = -1;
      for (int i = 0; i < 20; i++) begin
         #2;
         if (f_dev != 16'h0000) begin
            cyc_q.push_back(cyc);
            dat_q.push_back(f_data);
         end else begin
            check("fast_idle_data", 32'(f_data), 32'h0);
         end
         if (first_rdy < 0 && f_ready) first_rdy = cyc;
         @(negedge clk);
      end
      check("fast_write_count", cyc_q.size(), 6);
      for (int k = 0; k < cyc_q.size(); k++) begin
         check("fast_wr_cycle", cyc_q[k], t + 2 + k);
         check("fast_wr_data", 32'(dat_q[k]), 32'({5'b00001, 4'b0000, model_col(8'h41, k)}));
      end
      check("fast_ready_rise", first_rdy, t + 8);
   endtask

   initial begin
      int w0, a0;
      bit done;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #3;
      check("ready_after_por", 32'(char_ready), 32'h1);

      // Directed glyph and out-of-range code.
      send_char(8'h41);
      send_char(8'h7B);

      // Clear and character together: clear wins, character is dropped.
      wait_idle();
      w0 = wr_total;
      a0 = acc_total;
      @(negedge clk);
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_code  = 8'h41;
      @(negedge clk);
      clear_req  = 1'b0;
      char_valid = 1'b0;
      wait_idle();
      check("clear_writes", wr_total - w0, 30);

      // Three characters with char_valid held high throughout.
      w0 = wr_total;
      a0 = acc_total;
      done = 1'b0;
      @(negedge clk);
      char_valid = 1'b1;
      char_code  = pick_code();
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (acc_total == a0 + 3) begin
            char_valid = 1'b0;
            done = 1'b1;
         end else if (acc_total != a0 + i) begin
            char_code = pick_code();
         end
      end
      char_valid = 1'b0;
      check("b2b_accepts", acc_total - a0, 3);
      wait_idle();
      check("b2b_writes", wr_total - w0, 18);

      // Random traffic, including requests while busy.
      repeat (2500) begin
         @(negedge clk);
         char_valid = 1'($urandom_range(0, 1));
         char_code  = pick_code();
         clear_req  = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      char_valid = 1'b0;
      clear_req  = 1'b0;
      wait_idle();

      // Reset in the middle of a glyph.
      send_char(8'h41);
      repeat (8) @(negedge clk);
      pulse_reset();
      send_char(8'h7B);
      wait_idle();

      fast_test();

      wait_idle();
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule
